// File: rtl/ctrl_pkg.sv
// Shared definitions for the serial control-register block: op encodings,
// FSM states, error counter width and the register update rule.
package ctrl_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic [31:0] apply_op(input op_e op, input logic [31:0] cur,
                                           input logic [31:0] data);
    case (op)
      OP_WR:   return data;
      OP_SET:  return cur | data;
      OP_CLR:  return cur & ~data;
      OP_TGL:  return cur ^ data;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sync.sv
// Synchronizes the serial clock/data pins into clk_i and decodes START, STOP
// and bit-sample events from the synchronized levels and their history.
module ctrl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic ctrl_clk_i,
  input  logic ctrl_data_i,
  output logic start_o,
  output logic stop_o,
  output logic bit_o,
  output logic bit_val_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_hist_q;
  logic                   dat_hist_q;
  logic                   sclk;
  logic                   sdat;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_hist_q <= 1'b0;
      dat_hist_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ctrl_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ctrl_data_i};
      clk_hist_q <= clk_sync_q[SYNC_STAGES-1];
      dat_hist_q <= dat_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];

  assign start_o   = sclk & dat_hist_q & ~sdat;
  assign stop_o    = sclk & ~dat_hist_q & sdat;
  // A clock rise that coincides with a data edge is part of that condition,
  // not a data bit; this lets a frame ending in 1 be closed cleanly.
  assign bit_o     = sclk & ~clk_hist_q & ~start_o & ~stop_o;
  assign bit_val_o = sdat;

endmodule

// File: rtl/ctrl_regs.sv
// Bank of NUM_REGS control registers written by framed serial commands
// (op, addr, data, LSB first) delimited by START/STOP conditions.
module ctrl_regs
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       ctrl_clk_i,
  input  logic                       ctrl_data_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       upd_o,
  output logic [ADDR_W-1:0]          upd_idx_o,
  output logic                       busy_o,
  output logic [ERR_W-1:0]           err_cnt_o
);

  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT    = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]   NUM_REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

  logic start, stop, bit_evt, bit_val;

  ctrl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .ctrl_clk_i (ctrl_clk_i),
    .ctrl_data_i(ctrl_data_i),
    .start_o    (start),
    .stop_o     (stop),
    .bit_o      (bit_evt),
    .bit_val_o  (bit_val)
  );

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                upd_q, upd_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ERR_W-1:0]    err_q, err_d;

  op_e                 f_op;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_data;
  logic                accept;

  assign f_op   = op_e'(sr_q[1:0]);
  assign f_addr = sr_q[2 +: ADDR_W];
  assign f_data = sr_q[2+ADDR_W +: DATA_W];
  assign accept = (cnt_q == FRAME_CNT) && !ovf_q && ({1'b0, f_addr} < NUM_REGS_LIM);

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    regs_d  = regs_q;
    upd_d   = 1'b0;
    idx_d   = idx_q;
    err_d   = err_q;

    if (start) begin
      state_d = ST_ACTIVE;
      sr_d    = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_ACTIVE) begin
      if (stop) begin
        state_d = ST_IDLE;
        if (accept) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            if (f_addr == ADDR_W'(r)) begin
              regs_d[r] = DATA_W'(apply_op(f_op, 32'(regs_q[r]), 32'(f_data)));
            end
          end
          upd_d = 1'b1;
          idx_d = f_addr;
        end else if (err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
      end else if (bit_evt) begin
        // The count stops at FRAME_W so it can never wrap back to a legal length.
        if (cnt_q == FRAME_CNT) begin
          ovf_d = 1'b1;
        end else begin
          sr_d  = {bit_val, sr_q[FRAME_W-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      // NOTE: the register file is small and must read 0 out of reset, so it is built from resettable flops.
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      upd_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      regs_q  <= regs_d;
      upd_q   <= upd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign upd_o     = upd_q;
  assign upd_idx_o = idx_q;
  assign busy_o    = (state_q == ST_ACTIVE);
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_ctrl_regs.sv
// Self-checking bench for ctrl_regs: drives serial frames on the pins and
// compares the register bank, update pulses and error count to a frame model.
module tb_ctrl_regs;

  localparam int NR  = 3;
  localparam int AW  = 2;
  localparam int DW  = 16;
  localparam int SS  = 2;
  localparam int FW  = 2 + AW + DW;
  localparam int H   = 3;
  localparam int CLK = 10;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic            cclk = 1'b1;
  logic            cdat = 1'b1;
  logic [NR*DW-1:0] regs_w;
  logic            upd_w;
  logic [AW-1:0]   idx_w;
  logic            busy_w;
  logic [7:0]      err_w;

  ctrl_regs #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .ctrl_clk_i (cclk),
    .ctrl_data_i(cdat),
    .regs_o     (regs_w),
    .upd_o      (upd_w),
    .upd_idx_o  (idx_w),
    .busy_o     (busy_w),
    .err_cnt_o  (err_w)
  );

  always #(CLK/2) clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          upd_total = 0;
  int          exp_upd = 0;
  logic [AW-1:0] last_idx = '0;
  logic        prev_upd = 1'b0;
  time         stop_t = 0;
  logic [DW-1:0] m_regs [NR];
  int          m_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int lat;
    if (prev_upd) check("upd_width", 64'(upd_w), 64'd0);
    if (upd_w && !prev_upd) begin
      upd_total++;
      last_idx = idx_w;
      lat = int'(($time - stop_t) / CLK);
      check("upd_latency_in_range", 64'(lat >= SS + 1 && lat <= SS + 3), 64'd1);
    end
    prev_upd = upd_w;
  end

  task automatic hold();
    repeat (H) @(negedge clk);
  endtask

  task automatic start_cond();
    if (!(cclk && cdat)) begin
      cclk = 1'b0; hold();
      cdat = 1'b1; hold();
      cclk = 1'b1; hold();
    end
    cdat = 1'b0; hold();
  endtask

  task automatic send_bit(input logic b);
    cclk = 1'b0; hold();
    cdat = b;    hold();
    cclk = 1'b1; hold();
  endtask

  task automatic stop_cond();
    if (cclk && !cdat) begin
      cdat = 1'b1; stop_t = $time; hold();
    end else begin
      cclk = 1'b0; hold();
      cdat = 1'b0; hold();
      cclk = 1'b1; cdat = 1'b1; stop_t = $time; hold();
    end
  endtask

  task automatic partial(input int nbits);
    start_cond();
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
  endtask

  task automatic check_state();
    for (int r = 0; r < NR; r++)
      check($sformatf("reg%0d", r), 64'(regs_w[r*DW +: DW]), 64'(m_regs[r]));
    check("err_cnt", 64'(err_w), 64'(m_err));
    check("upd_count", 64'(upd_total), 64'(exp_upd));
    check("busy_idle", 64'(busy_w), 64'd0);
  endtask

  task automatic frame(input logic [1:0] op, input int addr, input logic [DW-1:0] data,
                       input int nbits);
    logic [FW-1:0] vec;
    logic [31:0]   a32;
    bit            ok;
    a32 = 32'(addr);
    vec = {data, a32[AW-1:0], op};
    start_cond();
    for (int i = 0; i < nbits; i++) send_bit(i < FW ? vec[i] : 1'($urandom));
    check("busy_active", 64'(busy_w), 64'd1);
    stop_cond();
    repeat (8) @(negedge clk);
    ok = (nbits == FW) && (addr < NR);
    if (ok) begin
      case (op)
        2'd0: m_regs[addr] = data;
        2'd1: m_regs[addr] = m_regs[addr] | data;
        2'd2: m_regs[addr] = m_regs[addr] & ~data;
        default: m_regs[addr] = m_regs[addr] ^ data;
      endcase
      exp_upd++;
    end else if (m_err < 255) begin
      m_err++;
    end
    check_state();
    if (ok) check("upd_idx", 64'(last_idx), 64'(addr));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    repeat (3) @(negedge clk);
    check("rst_regs", 64'(regs_w), 64'd0);
    check("rst_busy", 64'(busy_w), 64'd0);
    check("rst_upd", 64'(upd_w), 64'd0);
    check("rst_idx", 64'(idx_w), 64'd0);
    check("rst_err", 64'(err_w), 64'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    frame(2'd0, 2, 16'hA5C3, FW);
    check("wr_reg2", 64'(regs_w[47:32]), 64'hA5C3);
    frame(2'd1, 2, 16'h000C, FW);
    check("set_reg2", 64'(regs_w[47:32]), 64'hA5CF);
    frame(2'd2, 2, 16'h00F0, FW);
    check("clr_reg2", 64'(regs_w[47:32]), 64'hA50F);
    frame(2'd3, 2, 16'hFFFF, FW);
    check("tgl_reg2", 64'(regs_w[47:32]), 64'h5AF0);

    frame(2'($urandom), 0, 16'($urandom), FW - 1);
    check("short_err", 64'(err_w), 64'd1);
    frame(2'($urandom), 1, 16'($urandom), FW + 1);
    check("long_err", 64'(err_w), 64'd2);
    frame(2'd0, 3, 16'h1111, FW);
    check("bad_addr_err", 64'(err_w), 64'd3);

    partial(10);
    frame(2'd0, 1, 16'h1234, FW);
    check("restart_reg1", 64'(regs_w[31:16]), 64'h1234);
    check("restart_err", 64'(err_w), 64'd3);

    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: frame(2'($urandom), int'($urandom_range(0, 2)), 16'($urandom), FW - 1);
        1: frame(2'($urandom), int'($urandom_range(0, 2)), 16'($urandom), FW + 1);
        2: frame(2'($urandom), 3, 16'($urandom), FW);
        3: begin
          partial(int'($urandom_range(1, FW + 2)));
          frame(2'($urandom), int'($urandom_range(0, 2)), 16'($urandom), FW);
        end
        default: frame(2'($urandom), int'($urandom_range(0, 2)), 16'($urandom), FW);
      endcase
    end

    for (int k = 0; k < 300; k++) frame(2'($urandom), 0, 16'($urandom), 2);
    check("err_saturated", 64'(err_w), 64'd255);

    start_cond();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    #2 rstn = 1'b0;
    #1;
    check("midrst_regs", 64'(regs_w), 64'd0);
    check("midrst_busy", 64'(busy_w), 64'd0);
    check("midrst_err", 64'(err_w), 64'd0);
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_err = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    stop_cond();
    repeat (8) @(negedge clk);
    check_state();
    check("midrst_upd", 64'(upd_w), 64'd0);
    check("midrst_idx", 64'(idx_w), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
